multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock, reset asynchronous active-low; clock and reset first:
- clock  in  1  sole clock; all state changes on posedge
- Reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  data-memory completion handshake
- PCWre  out  1  PC update enable
- IRWre  out  1  instruction register load
- RegWre  out  1  register-file write enable; the file writes on negedge
- RegDst  out  2  00 rt, 01 rd, 10 r31
- WrRegDSrc  out  1  0 ALU/memory result, 1 PC+4
- ALUSrcB  out  1  0 register, 1 extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- ExtSel  out  1  0 zero-extend, 1 sign-extend
- mRD  out  1  memory read
- mWR  out  1  memory write
- DBDataSrc  out  1  0 ALU, 1 memory
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
- state  out  3  current FSM state, for debug

Function
REQ-002 States SHALL be IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
REQ-003 Transitions SHALL be:
- IF->ID always.
- ID by opcode:
  - R/addi/ori (000000/001000/001101) -> EXE_AL
  - lw/sw (100011/101011) -> EXE_LS
  - beq (000100) -> EXE_BR
  - j/jal (000010/000011) -> IF
  - halt (111111) -> ID
  - any other opcode -> IF (treated as nop)
- EXE_AL->WB_AL; WB_AL->IF.
- EXE_LS->MEM.
- MEM: mem_ready=0 -> stay in MEM; mem_ready=1 -> WB_LD for lw, IF for sw.
- WB_LD->IF.
- EXE_BR->IF.
REQ-004 Outputs SHALL be Moore-decoded from state and latched opcode/funct only; zero SHALL affect PCSrc only in EXE_BR.
REQ-005 IRWre SHALL be 1 only in IF.
REQ-006 PCWre SHALL be 1 for exactly one cycle per instruction, in its final state:
- WB_AL, WB_LD, EXE_BR
- MEM with mem_ready=1 for sw
- ID for j, jal and nop
- never for halt
REQ-007 RegWre SHALL be 1 only in these states:
- WB_AL: RegDst 01 for R-type, 00 for addi/ori.
- WB_LD: RegDst 00, DBDataSrc 1.
- ID for jal: RegDst 10, WrRegDSrc 1.
REQ-008 Writes to register 0 SHALL NOT be suppressed here; the register file ignores them.
REQ-009 mRD SHALL be 1 in MEM for lw; mWR SHALL be 1 in MEM for sw; both SHALL hold for every stall cycle.
REQ-010 ALUOp SHALL come from funct for R-type: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; unknown funct SHALL give add.
REQ-011 ALUOp for other instructions: addi/lw/sw add; ori or; beq sub.
REQ-012 ExtSel SHALL be 0 for ori, otherwise 1.
REQ-013 PCSrc SHALL be 01 in EXE_BR when zero=1, 10 in ID for j/jal, otherwise 00.
REQ-014 opcode/funct SHALL be sampled into an internal register at the ID posedge and used through the end of the instruction.
REQ-015 Halt SHALL hold ID with all enables 0 until Reset.

Reset
REQ-016 While Reset=0:
- state=IF
- all outputs 0, except IRWre, which is 1 per REQ-005 once state=IF
- latched opcode=000000
REQ-017 Reset asserted mid-instruction, including in MEM stall, SHALL abort it with no further RegWre/mWR; first fetch SHALL occur at the first posedge after release.

Structure
REQ-018 Opcode, funct, state and ALUOp encodings SHALL live in shared package cpu_defs.
REQ-019 Combinational decode of latched opcode/funct to per-instruction controls SHALL be sub-module instr_decode; the FSM stays in multi_cycle_ctrl.

Verification
REQ-020 Directed scenarios:
- R-type add (funct 100000): states IF,ID,EXE_AL,WB_AL; RegWre=1 and RegDst=01 only in WB_AL; one PCWre pulse.
- lw with mem_ready low 3 cycles: MEM held 4 cycles with mRD=1; then WB_LD with RegWre=1, DBDataSrc=1; total 8 cycles.
- beq, zero=1 then zero=0: 3 cycles each; PCSrc=01 in EXE_BR only when zero=1; RegWre never 1.
- jal: 2 cycles; ID drives RegWre=1, RegDst=10, WrRegDSrc=1, PCSrc=10, PCWre=1.
- halt (111111): state stuck at 001, PCWre=0 for 20 cycles; Reset low returns state to 000.
- Reset pulsed low in MEM of sw: mWR drops same cycle, state=000, no PCWre pulse.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the multi-cycle controller: opcodes, funct codes,
// FSM states, ALU operations and the decoded-instruction bundle.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  localparam logic [1:0] PCS_SEQ    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_LD  = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_e;

  // Instruction class selects the FSM path taken out of ID.
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_AL   = 3'd1,
    CLS_LS   = 3'd2,
    CLS_BR   = 3'd3,
    CLS_JMP  = 3'd4,
    CLS_HALT = 3'd5
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic       is_r;
    logic       is_lw;
    logic       is_jal;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       alu_src_b;
  } dec_t;

  function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the latched opcode/funct into per-instruction
// control attributes; state-independent.
module instr_decode
  import cpu_defs::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o           = '0;
    dec_o.cls       = CLS_NOP;
    dec_o.alu_op    = ALU_ADD;
    dec_o.ext_sel   = 1'b1;
    dec_o.alu_src_b = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        dec_o.cls    = CLS_AL;
        dec_o.is_r   = 1'b1;
        dec_o.alu_op = funct_to_alu(fn_i);
      end
      OP_ADDI: begin
        dec_o.cls       = CLS_AL;
        dec_o.alu_src_b = 1'b1;
      end
      OP_ORI: begin
        dec_o.cls       = CLS_AL;
        dec_o.alu_src_b = 1'b1;
        dec_o.ext_sel   = 1'b0;
        dec_o.alu_op    = ALU_OR;
      end
      OP_LW: begin
        dec_o.cls       = CLS_LS;
        dec_o.is_lw     = 1'b1;
        dec_o.alu_src_b = 1'b1;
      end
      OP_SW: begin
        dec_o.cls       = CLS_LS;
        dec_o.alu_src_b = 1'b1;
      end
      OP_BEQ: begin
        dec_o.cls    = CLS_BR;
        dec_o.alu_op = ALU_SUB;
      end
      OP_J: begin
        dec_o.cls = CLS_JMP;
      end
      OP_JAL: begin
        dec_o.cls    = CLS_JMP;
        dec_o.is_jal = 1'b1;
      end
      OP_HALT: begin
        dec_o.cls = CLS_HALT;
      end
      default: begin
        dec_o.cls = CLS_NOP;
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables from the current state and latched instruction.
module multi_cycle_ctrl
  import cpu_defs::*;
(
  input  logic       clock,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;
  dec_t       dec;

  instr_decode u_dec (
    .op_i  (op_q),
    .fn_i  (fn_q),
    .dec_o (dec)
  );

  // The instruction is captured on the edge that enters ID and held until
  // the next fetch, so a halt keeps its opcode for as long as it sits in ID.
  always_comb begin
    op_d = op_q;
    fn_d = fn_q;
    if (state_q == ST_IF) begin
      op_d = opcode;
      fn_d = funct;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IF;
      op_q    <= 6'b000000;
      fn_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        case (dec.cls)
          CLS_AL:   state_d = ST_EXE_AL;
          CLS_LS:   state_d = ST_EXE_LS;
          CLS_BR:   state_d = ST_EXE_BR;
          CLS_HALT: state_d = ST_ID;
          default:  state_d = ST_IF;
        endcase
      end
      ST_EXE_AL: state_d = ST_WB_AL;
      ST_WB_AL:  state_d = ST_IF;
      ST_EXE_LS: state_d = ST_MEM;
      ST_MEM: begin
        if (mem_ready) begin
          state_d = dec.is_lw ? ST_WB_LD : ST_IF;
        end
      end
      ST_WB_LD:  state_d = ST_IF;
      ST_EXE_BR: state_d = ST_IF;
      default:   state_d = ST_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = RDST_RT;
    WrRegDSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = PCS_SEQ;
    // Datapath selects stay quiet during fetch so reset leaves only IRWre high.
    if (state_q != ST_IF) begin
      ALUSrcB = dec.alu_src_b;
      ALUOp   = dec.alu_op;
      ExtSel  = dec.ext_sel;
    end
    case (state_q)
      ST_IF: IRWre = 1'b1;
      ST_ID: begin
        if (dec.cls == CLS_JMP) begin
          PCWre = 1'b1;
          PCSrc = PCS_JUMP;
          if (dec.is_jal) begin
            RegWre    = 1'b1;
            RegDst    = RDST_R31;
            WrRegDSrc = 1'b1;
          end
        end else if (dec.cls == CLS_NOP) begin
          PCWre = 1'b1;
        end
      end
      ST_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
        RegDst = dec.is_r ? RDST_RD : RDST_RT;
      end
      ST_MEM: begin
        if (dec.is_lw) begin
          mRD = 1'b1;
        end else begin
          mWR   = 1'b1;
          PCWre = mem_ready;
        end
      end
      ST_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = RDST_RT;
        DBDataSrc = 1'b1;
      end
      ST_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = zero ? PCS_BRANCH : PCS_SEQ;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class cycle by
// cycle and compares state plus the full control vector against hand values.
module tb_multi_cycle_ctrl;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;

  int checks = 0;
  int failures = 0;

  multi_cycle_ctrl dut (
    .clock(clock), .Reset(Reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .mRD(mRD),
    .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .state(state)
  );

  always #5 clock = ~clock;

  logic [15:0] ctl;
  assign ctl = {PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ALUOp,
                ExtSel, mRD, mWR, DBDataSrc, PCSrc};

  function automatic logic [15:0] mk(input logic pcw, input logic irw,
      input logic rw, input logic [1:0] rd, input logic wrs, input logic srcb,
      input logic [2:0] aop, input logic ext, input logic mrd, input logic mwr,
      input logic dbs, input logic [1:0] pcs);
    return {pcw, irw, rw, rd, wrs, srcb, aop, ext, mrd, mwr, dbs, pcs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample mid-cycle at negedge, then move just past the next posedge.
  task automatic cyc(input string tag, input logic [2:0] st,
                     input logic [15:0] c);
    @(negedge clock);
    chk({tag, " state"}, {29'd0, state}, {29'd0, st});
    chk({tag, " ctl"}, {16'd0, ctl}, {16'd0, c});
    $display("cycle %-14s state=%0d ctl=%h", tag, state, ctl);
    @(posedge clock);
    #1;
  endtask

  logic [15:0] c_if;

  initial begin
    c_if = mk(0,1,0,2'b00,0,0,3'b000,0,0,0,0,2'b00);

    // Reset state
    #12;
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset ctl", {16'd0, ctl}, {16'd0, c_if});
    @(posedge clock); #1;
    Reset = 1'b1;

    // R-type add
    opcode = 6'b000000; funct = 6'b100000;
    cyc("add IF", 3'd0, c_if);
    cyc("add ID", 3'd1, mk(0,0,0,2'b00,0,0,3'b000,1,0,0,0,2'b00));
    cyc("add EXE_AL", 3'd6, mk(0,0,0,2'b00,0,0,3'b000,1,0,0,0,2'b00));
    cyc("add WB_AL", 3'd7, mk(1,0,1,2'b01,0,0,3'b000,1,0,0,0,2'b00));

    // R-type slt
    funct = 6'b101010;
    cyc("slt IF", 3'd0, c_if);
    cyc("slt ID", 3'd1, mk(0,0,0,2'b00,0,0,3'b100,1,0,0,0,2'b00));
    cyc("slt EXE_AL", 3'd6, mk(0,0,0,2'b00,0,0,3'b100,1,0,0,0,2'b00));
    cyc("slt WB_AL", 3'd7, mk(1,0,1,2'b01,0,0,3'b100,1,0,0,0,2'b00));

    // ori, with the opcode input changed after fetch to prove it is latched
    opcode = 6'b001101; funct = 6'b000000;
    cyc("ori IF", 3'd0, c_if);
    opcode = 6'b100011;
    cyc("ori ID", 3'd1, mk(0,0,0,2'b00,0,1,3'b011,0,0,0,0,2'b00));
    cyc("ori EXE_AL", 3'd6, mk(0,0,0,2'b00,0,1,3'b011,0,0,0,0,2'b00));
    cyc("ori WB_AL", 3'd7, mk(1,0,1,2'b00,0,1,3'b011,0,0,0,0,2'b00));

    // lw with three stall cycles in MEM
    opcode = 6'b100011; mem_ready = 1'b0;
    cyc("lw IF", 3'd0, c_if);
    cyc("lw ID", 3'd1, mk(0,0,0,2'b00,0,1,3'b000,1,0,0,0,2'b00));
    cyc("lw EXE_LS", 3'd2, mk(0,0,0,2'b00,0,1,3'b000,1,0,0,0,2'b00));
    for (int i = 0; i < 3; i++)
      cyc("lw MEM stall", 3'd3, mk(0,0,0,2'b00,0,1,3'b000,1,1,0,0,2'b00));
    mem_ready = 1'b1;
    cyc("lw MEM ready", 3'd3, mk(0,0,0,2'b00,0,1,3'b000,1,1,0,0,2'b00));
    mem_ready = 1'b0;
    cyc("lw WB_LD", 3'd4, mk(1,0,1,2'b00,0,1,3'b000,1,0,0,1,2'b00));

    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1;
    cyc("beqT IF", 3'd0, c_if);
    cyc("beqT ID", 3'd1, mk(0,0,0,2'b00,0,0,3'b001,1,0,0,0,2'b00));
    cyc("beqT EXE_BR", 3'd5, mk(1,0,0,2'b00,0,0,3'b001,1,0,0,0,2'b01));
    zero = 1'b0;
    cyc("beqN IF", 3'd0, c_if);
    cyc("beqN ID", 3'd1, mk(0,0,0,2'b00,0,0,3'b001,1,0,0,0,2'b00));
    cyc("beqN EXE_BR", 3'd5, mk(1,0,0,2'b00,0,0,3'b001,1,0,0,0,2'b00));

    // jal, j and an unknown opcode (nop)
    opcode = 6'b000011;
    cyc("jal IF", 3'd0, c_if);
    cyc("jal ID", 3'd1, mk(1,0,1,2'b10,1,0,3'b000,1,0,0,0,2'b10));
    opcode = 6'b000010;
    cyc("j IF", 3'd0, c_if);
    cyc("j ID", 3'd1, mk(1,0,0,2'b00,0,0,3'b000,1,0,0,0,2'b10));
    opcode = 6'b010101;
    cyc("nop IF", 3'd0, c_if);
    cyc("nop ID", 3'd1, mk(1,0,0,2'b00,0,0,3'b000,1,0,0,0,2'b00));

    // halt holds ID, then async reset
    opcode = 6'b111111;
    cyc("halt IF", 3'd0, c_if);
    for (int i = 0; i < 20; i++)
      cyc("halt ID", 3'd1, mk(0,0,0,2'b00,0,0,3'b000,1,0,0,0,2'b00));
    #2;
    Reset = 1'b0;
    #1;
    chk("halt reset state", {29'd0, state}, 32'd0);
    chk("halt reset ctl", {16'd0, ctl}, {16'd0, c_if});
    @(posedge clock); #1;
    Reset = 1'b1;

    // sw interrupted by reset during a MEM stall
    opcode = 6'b101011; mem_ready = 1'b0;
    cyc("sw IF", 3'd0, c_if);
    cyc("sw ID", 3'd1, mk(0,0,0,2'b00,0,1,3'b000,1,0,0,0,2'b00));
    cyc("sw EXE_LS", 3'd2, mk(0,0,0,2'b00,0,1,3'b000,1,0,0,0,2'b00));
    @(negedge clock);
    chk("sw MEM state", {29'd0, state}, 32'd3);
    chk("sw MEM ctl", {16'd0, ctl}, {16'd0, mk(0,0,0,2'b00,0,1,3'b000,1,0,1,0,2'b00)});
    mem_ready = 1'b1;
    #1;
    chk("sw MEM ready ctl", {16'd0, ctl}, {16'd0, mk(1,0,0,2'b00,0,1,3'b000,1,0,1,0,2'b00)});
    mem_ready = 1'b0;
    #1;
    Reset = 1'b0;
    #1;
    chk("sw reset state", {29'd0, state}, 32'd0);
    chk("sw reset ctl", {16'd0, ctl}, {16'd0, c_if});
    @(posedge clock); #1;
    chk("sw held state", {29'd0, state}, 32'd0);
    chk("sw held ctl", {16'd0, ctl}, {16'd0, c_if});
    Reset = 1'b1;

    // recovery: sw completes with a single PCWre in MEM
    mem_ready = 1'b1;
    cyc("sw2 IF", 3'd0, c_if);
    cyc("sw2 ID", 3'd1, mk(0,0,0,2'b00,0,1,3'b000,1,0,0,0,2'b00));
    cyc("sw2 EXE_LS", 3'd2, mk(0,0,0,2'b00,0,1,3'b000,1,0,0,0,2'b00));
    cyc("sw2 MEM", 3'd3, mk(1,0,0,2'b00,0,1,3'b000,1,0,1,0,2'b00));
    cyc("sw2 next IF", 3'd0, c_if);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
